// File: rtl/sharpen_frame_ctrl.sv
// rtl/sharpen_frame_ctrl.sv - frame sequencer: SOF-aligned sharpen select, position tracking, border flag, framing errors.
// Optional completed-frame counter enabled by SHARPEN_FRAME_CNT_EN.
module sharpen_frame_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tready,
  input  logic             s_axis_tuser,
  input  logic             s_axis_tlast,
  input  logic             cfg_sharpen_en,
  input  logic             err_clr,
  output logic             hwsw_sel,
  output logic             border,
  output logic [CNT_W-1:0] col_cnt,
  output logic [CNT_W-1:0] row_cnt,
  output logic             frame_done,
  output logic             err_early_eol,
  output logic             err_late_eol,
  output logic             err_sof,
  output logic             busy,
  output logic [15:0]      frame_cnt
);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESYNC} state_t;

  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);

  state_t           state;
  logic             beat;
  logic             take;
  logic             mid_sof;
  logic [CNT_W-1:0] cur_col;
  logic [CNT_W-1:0] cur_row;
  logic             at_last_col;
  logic             at_last_row;
  logic             early;
  logic             late;

  assign beat = s_axis_tvalid & s_axis_tready;

  // A tuser beat is repositioned to (0,0) first; tlast is then judged at that position.
  assign cur_col     = s_axis_tuser ? '0 : col_cnt;
  assign cur_row     = s_axis_tuser ? '0 : row_cnt;
  assign at_last_col = (cur_col == LAST_COL);
  assign at_last_row = (cur_row == LAST_ROW);

  assign take    = beat & ((state == ACTIVE) | s_axis_tuser);
  assign mid_sof = beat & s_axis_tuser & (state == ACTIVE) &
                   ((col_cnt != '0) | (row_cnt != '0));
  assign early   = take &  s_axis_tlast & ~at_last_col;
  assign late    = take & ~s_axis_tlast &  at_last_col;

  assign border = (col_cnt == '0) | (col_cnt == LAST_COL) |
                  (row_cnt == '0) | (row_cnt == LAST_ROW);
  assign busy   = (state == ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      hwsw_sel      <= 1'b0;
      col_cnt       <= '0;
      row_cnt       <= '0;
      frame_done    <= 1'b0;
      err_early_eol <= 1'b0;
      err_late_eol  <= 1'b0;
      err_sof       <= 1'b0;
    end else begin
      frame_done    <= 1'b0;
      err_early_eol <= (err_early_eol & ~err_clr) | early;
      err_late_eol  <= (err_late_eol  & ~err_clr) | late;
      err_sof       <= (err_sof       & ~err_clr) | mid_sof;
      if (take) begin
        if (s_axis_tuser) hwsw_sel <= cfg_sharpen_en;
        if (early | late) begin
          state    <= RESYNC;
          hwsw_sel <= 1'b0;
          col_cnt  <= '0;
          row_cnt  <= '0;
        end else if (at_last_col) begin
          col_cnt <= '0;
          if (at_last_row) begin
            row_cnt    <= '0;
            state      <= IDLE;
            frame_done <= 1'b1;
          end else begin
            row_cnt <= cur_row + CNT_W'(1);
            state   <= ACTIVE;
          end
        end else begin
          col_cnt <= cur_col + CNT_W'(1);
          row_cnt <= cur_row;
          state   <= ACTIVE;
        end
      end
    end
  end

`ifdef SHARPEN_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt <= '0;
    else if (frame_done) frame_cnt <= frame_cnt + 16'd1;
  end
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_sharpen_frame_ctrl.sv
// tb/tb_sharpen_frame_ctrl.sv - scoreboard bench for sharpen_frame_ctrl on a 4x3 image.
module tb_sharpen_frame_ctrl;

  localparam int W = 4;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0, ready = 1'b1, tuser = 1'b0, tlast = 1'b0;
  logic       cfg = 1'b1, err_clr = 1'b0;
  logic       hwsw_sel, border, frame_done, err_early_eol, err_late_eol, err_sof, busy;
  logic [3:0] col_cnt, row_cnt;
  logic [15:0] frame_cnt;

  typedef struct {int col; int row; int brd;} exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass = 0;
  int exp_frames = 0;

  sharpen_frame_ctrl #(.IMG_W(W), .IMG_H(H), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(valid), .s_axis_tready(ready),
    .s_axis_tuser(tuser), .s_axis_tlast(tlast),
    .cfg_sharpen_en(cfg), .err_clr(err_clr),
    .hwsw_sel(hwsw_sel), .border(border),
    .col_cnt(col_cnt), .row_cnt(row_cnt),
    .frame_done(frame_done),
    .err_early_eol(err_early_eol), .err_late_eol(err_late_eol), .err_sof(err_sof),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  function automatic int exp_fc();
`ifdef SHARPEN_FRAME_CNT_EN
    return exp_frames & 16'hffff;
`else
    return 0;
`endif
  endfunction

  // Position outputs must describe each accepted beat as it is presented.
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("col_cnt", col_cnt, e.col);
        check("row_cnt", row_cnt, e.row);
        check("border", border, e.brd);
      end
    end
  end

  task automatic drive(input logic u, input logic l, input int c, input int r, input int stall);
    exp_t e;
    e.col = c;
    e.row = r;
    e.brd = (c == 0 || c == W-1 || r == 0 || r == H-1) ? 1 : 0;
    sb.push_back(e);
    valid = 1'b1; tuser = u; tlast = l;
    if (stall > 0) begin
      ready = 1'b0;
      repeat (stall) begin
        @(posedge clk); #1;
        check("stall_col", col_cnt, c);
        check("stall_row", row_cnt, r);
      end
      ready = 1'b1;
    end
    @(posedge clk); #1;
    valid = 1'b0; tuser = 1'b0; tlast = 1'b0;
  endtask

  task automatic run_frame(input int sel_exp, input int stall_beat, input int toggle_beat);
    for (int i = 0; i < W*H; i++) begin
      if (i == toggle_beat) cfg = ~cfg;
      drive(i == 0, (i % W) == W-1, i % W, i / W, (i == stall_beat) ? 3 : 0);
      check("hwsw_sel", hwsw_sel, sel_exp);
      if (i < W*H-1) begin
        check("busy_mid", busy, 1);
        check("frame_done_early", frame_done, 0);
      end
    end
    exp_frames++;
    check("frame_done", frame_done, 1);
    check("busy_end", busy, 0);
    check("frame_cnt", frame_cnt, exp_fc());
    @(posedge clk); #1;
    check("frame_done_clear", frame_done, 0);
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("clr_early", err_early_eol, 0);
    check("clr_late", err_late_eol, 0);
    check("clr_sof", err_sof, 0);
  endtask

  initial begin
    #2;
    check("rst_hwsw", hwsw_sel, 0);
    check("rst_col", col_cnt, 0);
    check("rst_row", row_cnt, 0);
    check("rst_border", border, 1);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_errs", {err_early_eol, err_late_eol, err_sof}, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // clean frame, then same frame with a mid-line stall
    run_frame(1, -1, -1);
    check("clean_errs", {err_early_eol, err_late_eol, err_sof}, 0);
    run_frame(1, 5, -1);
    check("stall_errs", {err_early_eol, err_late_eol, err_sof}, 0);

    // early end-of-line, non-SOF beats ignored in resync, then recovery
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 1, 2, 0, 0);
    check("early_eol", err_early_eol, 1);
    check("early_sel", hwsw_sel, 0);
    check("early_busy", busy, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    check("resync_col", col_cnt, 0);
    run_frame(1, -1, -1);
    check("early_sticky", err_early_eol, 1);
    clear_errors();

    // missing tlast at the last column
    for (int c = 0; c < W; c++) drive(c == 0, 0, c, 0, 0);
    check("late_eol", err_late_eol, 1);
    check("late_busy", busy, 0);
    check("late_sel", hwsw_sel, 0);
    drive(0, 0, 0, 0, 0);
    check("late_resync_col", col_cnt, 0);
    clear_errors();

    // cfg toggled mid-frame takes effect only at the next SOF
    run_frame(1, -1, 5);
    run_frame(0, -1, -1);
    cfg = 1'b1;

    // tuser+tlast on the same SOF beat is an early end-of-line
    drive(1, 1, 0, 0, 0);
    check("sof_eol_early", err_early_eol, 1);
    check("sof_eol_busy", busy, 0);
    clear_errors();

    // mid-frame SOF at (1,2)
    for (int i = 0; i < 9; i++) drive(i == 0, (i % W) == W-1, i % W, i / W, 0);
    drive(1, 0, 1, 2, 0);
    check("mid_sof_err", err_sof, 1);
    check("mid_sof_col", col_cnt, 1);
    check("mid_sof_row", row_cnt, 0);
    check("mid_sof_busy", busy, 1);
    check("mid_sof_done", frame_done, 0);
    check("mid_sof_sel", hwsw_sel, 1);
    check("mid_sof_other_errs", {err_early_eol, err_late_eol}, 0);
    drive(0, 0, 1, 0, 0);

    // asynchronous reset mid-frame
    #2 rst_n = 1'b0;
    #1;
    exp_frames = 0;
    check("arst_col", col_cnt, 0);
    check("arst_row", row_cnt, 0);
    check("arst_busy", busy, 0);
    check("arst_sel", hwsw_sel, 0);
    check("arst_errs", {err_early_eol, err_late_eol, err_sof}, 0);
    check("arst_frame_cnt", frame_cnt, exp_fc());
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
